// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  // Largest supported master count; the pointer and the pick vector are sized for it.
  localparam int unsigned MAX_M = 8;
  localparam int unsigned PTR_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    ABORT    = 2'd2,
    WAIT_REL = 2'd3
  } arb_state_t;

  // One-hot grant to the first requester found scanning from ptr+1 modulo n.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                                input logic [PTR_W-1:0] ptr,
                                                input int unsigned      n);
    logic [MAX_M-1:0] g;
    logic             found;
    int unsigned      idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_M; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k <= n) && req[idx[PTR_W-1:0]]) begin
        g[idx[PTR_W-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_M-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-tenure watchdog: counts consecutive strobed cycles without a slave
// termination and flags expiry on the last allowed cycle.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic term,
  output logic expire
);

  localparam int unsigned      CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]    LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count strobed, unterminated cycles; any idle/strobe-low/termination restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || !stb || term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A termination on the final cycle wins over the abort.
  assign expire = active && stb && !term && (cnt == LAST);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port, grant
// held for a whole CYC tenure, with a watchdog that aborts hung transfers.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [NUM_M-1:0]        gnt_o,
  output logic                    timeout_o
);

  localparam int unsigned SW = DW / 8;

  arb_state_t        state, state_d;
  logic [NUM_M-1:0]  gnt, gnt_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [MAX_M-1:0]  req_ext;
  logic [MAX_M-1:0]  pick;

  logic              g_cyc, g_stb, g_we;
  logic [AW-1:0]     g_adr;
  logic [DW-1:0]     g_dat;
  logic [SW-1:0]     g_sel;
  logic              term;
  logic              expire;
  logic              wd_active;

  // Widen the request vector to the package's fixed pick width.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_M-1:0]   = m_cyc_i;
  end

  assign pick = rr_pick(req_ext, ptr, NUM_M);

  // Select the granted master's bus signals; zero when nobody holds the grant.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt[i]) begin
        g_cyc = g_cyc | m_cyc_i[i];
        g_stb = g_stb | m_stb_i[i];
        g_we  = g_we  | m_we_i[i];
        g_adr = g_adr | m_adr_i[i*AW +: AW];
        g_dat = g_dat | m_dat_i[i*DW +: DW];
        g_sel = g_sel | m_sel_i[i*SW +: SW];
      end
    end
  end

  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign wd_active = (state == GRANT);

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (CLK_I),
    .rst    (RST_I),
    .active (wd_active),
    .stb    (g_stb),
    .term   (term),
    .expire (expire)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= PTR_W'(NUM_M - 1);
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
    end
  end

  // Next-state: arbitrate only from IDLE, so every tenure ends with a dead cycle.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = GRANT;
          gnt_d   = pick[NUM_M-1:0];
          ptr_d   = onehot_to_idx(pick);
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (expire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs: slave sees the granted master only in GRANT; terminations go back to it alone.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = g_adr;
    s_dat_o   = g_dat;
    s_sel_o   = g_sel;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = 1'b0;
    case (state)
      GRANT: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = g_we;
        m_ack_o = gnt & {NUM_M{s_ack_i}};
        m_err_o = gnt & {NUM_M{s_err_i}};
        m_rty_o = gnt & {NUM_M{s_rty_i}};
      end
      ABORT: begin
        m_err_o   = gnt;
        timeout_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a tenure-level model.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    gnt_o;
  logic            timeout_o;

  int checks   = 0;
  int failures = 0;

  wb_rr_arbiter #(.NUM_M(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [63:0] adr, input logic [63:0] dat, input logic [7:0] sel);
    m_cyc[i]            = cyc;
    m_stb[i]            = stb;
    m_we[i]             = we;
    m_adr[i*AW +: AW]   = adr;
    m_dat[i*DW +: DW]   = dat;
    m_sel[i*SW +: SW]   = sel;
  endtask

  task automatic clear_all();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  // Reset held across a falling edge, released just after a rising edge.
  task automatic do_reset();
    step();
    clear_all();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference model (tenure level) ----------------
  // owner: master holding the bus (-1 none); mode: 0 transferring, 1 abort cycle, 2 awaiting release
  int md_owner = -1;
  int md_mode  = 0;
  int md_last  = N - 1;
  int md_wait  = 0;

  logic [N-1:0]  e_gnt, e_ack, e_err, e_rty;
  logic          e_scyc, e_sstb, e_swe, e_to;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;

  always @(negedge clk) begin
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_to = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (rst) begin
      md_owner = -1; md_mode = 0; md_last = N - 1; md_wait = 0;
    end else if (md_owner >= 0) begin
      e_gnt[md_owner] = 1'b1;
      e_adr = m_adr[md_owner*AW +: AW];
      e_dat = m_dat[md_owner*DW +: DW];
      e_sel = m_sel[md_owner*SW +: SW];
      if (md_mode == 0) begin
        e_scyc = m_cyc[md_owner];
        e_sstb = m_stb[md_owner];
        e_swe  = m_we[md_owner];
        e_ack[md_owner] = s_ack;
        e_err[md_owner] = s_err;
        e_rty[md_owner] = s_rty;
      end else if (md_mode == 1) begin
        e_err[md_owner] = 1'b1;
        e_to = 1'b1;
      end
    end
    chk("gnt", gnt_o, e_gnt);
    chk("s_cyc", s_cyc_o, e_scyc);
    chk("s_stb", s_stb_o, e_sstb);
    chk("s_we", s_we_o, e_swe);
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_dat);
    chk("s_sel", s_sel_o, e_sel);
    chk("m_ack", m_ack_o, e_ack);
    chk("m_err", m_err_o, e_err);
    chk("m_rty", m_rty_o, e_rty);
    chk("timeout", timeout_o, e_to);
    chk("m_dat", m_dat_o, s_dat);
    if (!rst) begin
      if (md_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (md_owner < 0 && m_cyc[(md_last + k) % N]) md_owner = (md_last + k) % N;
        end
        if (md_owner >= 0) begin
          md_last = md_owner; md_mode = 0; md_wait = 0;
        end
      end else if (md_mode == 0) begin
        if (!m_cyc[md_owner]) begin
          md_owner = -1;
        end else if (m_stb[md_owner] && !(s_ack || s_err || s_rty)) begin
          md_wait++;
          if (md_wait == TO) md_mode = 1;
        end else begin
          md_wait = 0;
        end
      end else if (md_mode == 1) begin
        md_mode = 2;
      end else if (!m_cyc[md_owner]) begin
        md_owner = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int order[$];
    int gaps[$];
    int idle_run;
    bit acked;
    int drop_g, rest_g, g;
    int drop_den[4] = '{6, 64, 40, 4};
    int ack_pct[4]  = '{33, 0, 6, 50};
    int err_pct[4]  = '{5, 0, 2, 10};
    int rty_pct[4]  = '{5, 0, 2, 10};
    int tog_pct[4]  = '{10, 0, 3, 20};
    int ph;

    rst = 1'b1;
    clear_all();
    s_dat = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_m_err", m_err_o, 0);
    step();
    rst = 1'b0;

    // Single master write, ACK in the second granted cycle
    step();
    set_m(0, 1, 1, 1, 64'h100, 64'hDEAD_BEEF, 8'hFF);
    @(negedge clk);
    chk("single_pre_gnt", gnt_o, 0);
    step();
    @(negedge clk);
    chk("single_gnt", gnt_o, 4'b0001);
    chk("single_adr", s_adr_o, 64'h100);
    chk("single_s_cyc", s_cyc_o, 1);
    step();
    s_ack = 1'b1;
    @(negedge clk);
    chk("single_ack", m_ack_o, 4'b0001);
    step();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_hold_gnt", gnt_o, 4'b0001);
    step();
    @(negedge clk);
    chk("single_release", gnt_o, 0);

    // Fairness: everyone requests, one transfer per tenure
    do_reset();
    m_cyc = '1; m_stb = '1;
    idle_run = 0; acked = 0; drop_g = -1; rest_g = -1;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      step();
      s_ack = 1'b0;
      if (rest_g >= 0) begin m_cyc[rest_g] = 1'b1; m_stb[rest_g] = 1'b1; end
      rest_g = drop_g;
      if (drop_g >= 0) begin m_cyc[drop_g] = 1'b0; m_stb[drop_g] = 1'b0; end
      drop_g = -1;
      if (gnt_o == '0) begin
        acked = 0;
        idle_run++;
      end else if (!acked) begin
        g = 0;
        for (int i = 0; i < N; i++) if (gnt_o[i]) g = i;
        if (order.size() > 0) gaps.push_back(idle_run);
        idle_run = 0;
        order.push_back(g);
        s_ack = 1'b1;
        acked = 1;
        drop_g = g;
      end
    end
    chk("fair_tenures", order.size(), 5);
    foreach (order[i]) chk("fair_order", order[i], i % N);
    foreach (gaps[i]) chk("fair_gap", gaps[i], 1);
    step();
    clear_all();
    step(); step(); step();

    // Pointer skip: pointer at 1, masters 0 and 3 request
    do_reset();
    set_m(1, 1, 1, 0, 64'h10, 0, 8'h0F);
    step();
    chk("skip_gnt1", gnt_o, 4'b0010);
    m_cyc = 4'b1001; m_stb = 4'b1001;
    step();
    chk("skip_dead", gnt_o, 0);
    step();
    chk("skip_gnt3", gnt_o, 4'b1000);
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    chk("skip_dead2", gnt_o, 0);
    step();
    chk("skip_gnt0", gnt_o, 4'b0001);
    clear_all();
    step(); step(); step();

    // Watchdog: slave never answers
    set_m(2, 1, 1, 0, 64'h200, 0, 8'hFF);
    for (int k = 1; k <= 19; k++) begin
      step();
      @(negedge clk);
      chk("wd_timeout", timeout_o, (k == 17) ? 1 : 0);
      if (k == 16) chk("wd_s_cyc_before", s_cyc_o, 1);
      if (k == 17) begin
        chk("wd_err", m_err_o, 4'b0100);
        chk("wd_s_cyc", s_cyc_o, 0);
      end
      if (k >= 18) begin
        chk("wd_hold_gnt", gnt_o, 4'b0100);
        chk("wd_rel_s_cyc", s_cyc_o, 0);
      end
    end
    step();
    set_m(2, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    chk("wd_release", gnt_o, 0);
    step(); step();

    // Race: ACK on the 16th strobed cycle beats the watchdog
    set_m(2, 1, 1, 1, 64'h300, 64'h55, 8'hFF);
    for (int k = 1; k <= 17; k++) begin
      step();
      s_ack = (k == 16);
      @(negedge clk);
      chk("race_timeout", timeout_o, 0);
      if (k == 16) chk("race_ack", m_ack_o, 4'b0100);
      if (k == 17) begin
        chk("race_no_err", m_err_o, 0);
        chk("race_s_cyc", s_cyc_o, 1);
      end
    end
    step();
    s_ack = 1'b0;
    set_m(2, 0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // Asynchronous reset mid-tenure
    set_m(1, 1, 1, 0, 64'h400, 0, 8'hFF);
    step();
    #2;
    chk("arst_pre_gnt", gnt_o, 4'b0010);
    chk("arst_pre_s_cyc", s_cyc_o, 1);
    rst = 1'b1;
    #1;
    chk("arst_s_cyc", s_cyc_o, 0);
    chk("arst_gnt", gnt_o, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    m_cyc = '1; m_stb = '1;
    step();
    chk("arst_first_winner", gnt_o, 4'b0001);
    clear_all();
    step(); step(); step();

    // Randomized traffic in phases of differing slave/master behaviour
    for (int chunk = 0; chunk < 8; chunk++) begin
      ph = chunk % 4;
      for (int c = 0; c < 250; c++) begin
        step();
        for (int i = 0; i < N; i++) begin
          if (!m_cyc[i]) begin
            if ($urandom_range(0, 3) == 0)
              set_m(i, 1, 1, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    {$urandom, $urandom}, 8'($urandom));
          end else if ($urandom_range(1, drop_den[ph]) == 1) begin
            set_m(i, 0, 0, 0, 0, 0, 0);
          end else if ($urandom_range(0, 99) < tog_pct[ph]) begin
            m_stb[i] = ~m_stb[i];
          end
        end
        s_ack = ($urandom_range(0, 99) < ack_pct[ph]);
        s_err = ($urandom_range(0, 99) < err_pct[ph]);
        s_rty = ($urandom_range(0, 99) < rty_pct[ph]);
        s_dat = {$urandom, $urandom};
      end
    end
    step();
    clear_all();
    step(); step();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port between NUM_M Wishbone masters using round-robin arbitration.
- Grant is held for a whole bus tenure, i.e. while the granted master holds CYC.
- A per-tenure watchdog aborts transfers the slave never terminates, returning ERR to the master.
- Sits between the testbench/SoC masters and the shared 64-bit slave-side interconnect.

Parameters:
NUM_M, 4, number of masters (2..8)
AW, 64, address width
DW, 64, data width; select width is DW/8
TIMEOUT, 16, cycles STB may stay high without ACK/ERR/RTY before abort (>=2)

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset, asynchronous, active-high
m_cyc_i  in  NUM_M  per-master CYC
m_stb_i  in  NUM_M  per-master STB
m_we_i  in  NUM_M  per-master WE
m_adr_i  in  NUM_M*AW  master i occupies bits [i*AW +: AW]
m_dat_i  in  NUM_M*DW  master write data, same packing
m_sel_i  in  NUM_M*DW/8  master byte selects, same packing
m_dat_o  out  DW  slave read data broadcast to all masters
m_ack_o  out  NUM_M  ACK routed to granted master only
m_err_o  out  NUM_M  ERR routed to granted master only (includes watchdog abort)
m_rty_o  out  NUM_M  RTY routed to granted master only
s_cyc_o, s_stb_o, s_we_o  out  1  to slave
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_sel_o  out  DW/8  to slave
s_dat_i  in  DW  slave read data
s_ack_i, s_err_i, s_rty_i  in  1  slave terminations
gnt_o  out  NUM_M  one-hot current grant, 0 when idle
timeout_o  out  1  one-cycle pulse on each watchdog abort

Behaviour:
- Reset: state IDLE; gnt_o=0; rr pointer=NUM_M-1, so master 0 wins first; watchdog=0; all s_* and m_ack/err/rty outputs 0; timeout_o=0.
- States:
  - IDLE: if any m_cyc_i, register a one-hot grant to the first requester found scanning from pointer+1 modulo NUM_M; set pointer to the winner; go to GRANT. One cycle of latency from CYC to s_cyc_o.
  - GRANT: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are combinational muxes from the granted master. s_ack_i/s_err_i/s_rty_i are routed combinationally to the granted master's bit; other masters see 0. m_dat_o = s_dat_i always.
  - GRANT exits:
    - Granted m_cyc_i low: go to IDLE and clear gnt_o next cycle. Always at least one dead cycle between tenures.
    - Watchdog reaches TIMEOUT-1 while STB high and no termination: go to ABORT.
  - ABORT (one cycle): s_cyc_o=s_stb_o=0; m_err_o[granted]=1; timeout_o=1; go to WAIT_REL.
  - WAIT_REL: s_cyc_o=0, no terminations passed; stay until granted m_cyc_i low, then go to IDLE.
- Watchdog counter, width clog2(TIMEOUT):
  - Cleared in IDLE, when STB is low, or on any of s_ack_i/s_err_i/s_rty_i.
  - Otherwise increments each GRANT cycle.
  - A termination arriving on the same cycle the count reaches TIMEOUT-1 wins: no abort.
- Non-granted masters receive no terminations and are never dropped; they wait.
- Masters that drop CYC before being granted are simply not selected; requests are not latched.
- Simultaneous ACK and ERR from the slave are both forwarded unchanged.
- RST_I asserted mid-tenure clears everything immediately (asynchronous), including s_cyc_o.
- Pointer wraps NUM_M-1 -> 0. Grant is always one-hot or zero, never multi-hot.

Decomposition:
- Package wb_arb_pkg holds the state enum (IDLE, GRANT, ABORT, WAIT_REL) and a function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, wb_arb_watchdog: the counter plus the compare, outputting the expire flag.
- Arbiter FSM and muxes stay in the top module.

Test Plan:
- Single master: m_cyc_i=4'b0001, write to adr 0x100, slave ACKs on 2nd cycle -> gnt_o=0001 one cycle after CYC; s_adr_o=0x100; m_ack_o=0001 the same cycle as s_ack_i.
- Fairness: all four masters hold CYC continuously, each doing one transfer per tenure -> grant order 0,1,2,3,0 with exactly one idle cycle between tenures.
- Pointer skip: pointer=1, only masters 0 and 3 request -> master 3 granted first, then master 0.
- Watchdog: slave never terminates, TIMEOUT=16 -> ERR and timeout_o pulse exactly 16 cycles after STB rises; s_cyc_o low in that cycle; grant held until the master drops CYC.
- Race: ACK arrives on cycle 16 of STB -> no abort, timeout_o stays 0.
- Reset mid-tenure: RST_I pulsed during GRANT -> s_cyc_o and gnt_o go to 0 without waiting for a clock edge; afterwards master 0 wins first again.
